// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: state register plus combinational decode.
// Optional illegal-opcode trap to HALT enabled by MCCTRL_ILLEGAL_TRAP_EN.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       adr_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control
`ifdef MCCTRL_ILLEGAL_TRAP_EN
  ,
  output logic       illegal
`endif
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL
`ifdef MCCTRL_ILLEGAL_TRAP_EN
    ,
    S_HALT
`endif
  } state_t;

  state_t     state;
  state_t     state_n;

  logic       pc_update;
  logic       branch;
  logic [1:0] aluop;
  logic       req_raw;
  logic       irw_raw;
  logic       mw_raw;
  logic       rw_raw;

  // state register, async reset to FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_n;
  end

  // next-state logic; memory states hold until mem_ready
  always_comb begin
    state_n = state;
    case (state)
      S_FETCH:    if (mem_ready) state_n = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_R:         state_n = S_EXECR;
          OP_I:         state_n = S_EXECI;
          OP_BEQ:       state_n = S_BEQ;
          OP_JAL:       state_n = S_JAL;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
          default:      state_n = S_HALT;
`else
          default:      state_n = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_n = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_n = S_MEMWB;
      S_MEMWB:    state_n = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_n = S_FETCH;
      S_EXECR:    state_n = S_ALUWB;
      S_EXECI:    state_n = S_ALUWB;
      S_JAL:      state_n = S_ALUWB;
      S_ALUWB:    state_n = S_FETCH;
      S_BEQ:      state_n = S_FETCH;
      default:    state_n = state;
    endcase
  end

  // per-state selects and raw strobes; access strobes fire on the ready cycle
  always_comb begin
    req_raw    = 1'b0;
    irw_raw    = 1'b0;
    mw_raw     = 1'b0;
    rw_raw     = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    aluop      = 2'b00;
    case (state)
      S_FETCH: begin
        req_raw    = 1'b1;
        irw_raw    = mem_ready;
        pc_update  = mem_ready;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        req_raw = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        rw_raw     = 1'b1;
      end
      S_MEMWRITE: begin
        req_raw = 1'b1;
        adr_src = 1'b1;
        mw_raw  = mem_ready;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        aluop     = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        aluop     = 2'b10;
      end
      S_ALUWB:  rw_raw = 1'b1;
      S_BEQ: begin
        alu_src_a = 2'b10;
        aluop     = 2'b01;
        branch    = 1'b1;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      default: begin
        req_raw = 1'b0;
      end
    endcase
  end

  assign mem_req   = req_raw & ~reset;
  assign ir_write  = irw_raw & ~reset;
  assign mem_write = mw_raw & ~reset;
  assign reg_write = rw_raw & ~reset;
  assign pc_write  = (pc_update | (branch & zero)) & ~reset;

  // ALU operation decode from aluop and instruction fields
  always_comb begin
    alu_control = 3'b000;
    case (aluop)
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  // immediate format decode from opcode
  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

`ifdef MCCTRL_ILLEGAL_TRAP_EN
  assign illegal = (state == S_HALT);
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: states identified by output signature.
module tb_multicycle_controller;
  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, pc_write, ir_write, mem_write, reg_write, adr_src;
  logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
  logic [2:0] alu_control;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  int checks = 0;
  int errors = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .pc_write(pc_write), .ir_write(ir_write),
    .mem_write(mem_write), .reg_write(reg_write), .adr_src(adr_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .imm_src(imm_src),
    .alu_control(alu_control)
`ifdef MCCTRL_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  always #5 clk = ~clk;

  // {mem_req,pc_write,ir_write,mem_write,reg_write,adr_src,a,b,rs}
  logic [11:0] sig;
  assign sig = {mem_req, pc_write, ir_write, mem_write, reg_write,
                adr_src, alu_src_a, alu_src_b, result_src};

  localparam logic [11:0] G_RST   = 12'b0000_0000_1010;
  localparam logic [11:0] G_FRDY  = 12'b1110_0000_1010;
  localparam logic [11:0] G_FSTL  = 12'b1000_0000_1010;
  localparam logic [11:0] G_DEC   = 12'b0000_0001_0100;
  localparam logic [11:0] G_MADR  = 12'b0000_0010_0100;
  localparam logic [11:0] G_MRD   = 12'b1000_0100_0000;
  localparam logic [11:0] G_MWB   = 12'b0000_1000_0001;
  localparam logic [11:0] G_MWRDY = 12'b1001_0100_0000;
  localparam logic [11:0] G_MWSTL = 12'b1000_0100_0000;
  localparam logic [11:0] G_EXR   = 12'b0000_0010_0000;
  localparam logic [11:0] G_EXI   = 12'b0000_0010_0100;
  localparam logic [11:0] G_AWB   = 12'b0000_1000_0000;
  localparam logic [11:0] G_BEQT  = 12'b0100_0010_0000;
  localparam logic [11:0] G_BEQN  = 12'b0000_0010_0000;
  localparam logic [11:0] G_JAL   = 12'b0100_0001_1000;
  localparam logic [11:0] G_HALT  = 12'b0000_0000_0000;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] exp);
    checks++;
    assert (sig === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, sig, exp);
    end
  endtask

  task automatic chk_alu(input string tag, input logic [2:0] exp);
    checks++;
    assert (alu_control === exp) else begin
      errors++;
      $error("FAIL %s: observed alu_control %b expected %b",
             tag, alu_control, exp);
    end
  endtask

  task automatic chk_imm(input string tag, input logic [1:0] exp);
    checks++;
    assert (imm_src === exp) else begin
      errors++;
      $error("FAIL %s: observed imm_src %b expected %b",
             tag, imm_src, exp);
    end
  endtask

  initial begin
    reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
    zero = 1'b0; mem_ready = 1'b1;
    cyc(); cyc();
    chk("reset_gated", G_RST);
`ifdef MCCTRL_ILLEGAL_TRAP_EN
    checks++;
    assert (illegal === 1'b0) else begin
      errors++;
      $error("FAIL illegal_rst: observed %b expected 0", illegal);
    end
`endif
    reset = 1'b0;
    #1 chk("first_req", G_FRDY);

    // lw, no stalls: F D MA MR WB
    op = 7'b0000011;
    cyc(); chk("lw_dec", G_DEC); chk_imm("lw_imm", 2'b00);
    cyc(); chk("lw_madr", G_MADR); chk_alu("lw_add", 3'b000);
    cyc(); chk("lw_mrd", G_MRD);
    cyc(); chk("lw_mwb", G_MWB);
    cyc(); chk("lw_done", G_FRDY);

    // fetch stall holds and produces no strobes
    mem_ready = 1'b0;
    #1 chk("f_stall0", G_FSTL);
    cyc(); chk("f_stall1", G_FSTL);
    mem_ready = 1'b1;
    #1 chk("f_ready", G_FRDY);

    // sw with 3 stall cycles in MEMWRITE
    op = 7'b0100011;
    cyc(); chk("sw_dec", G_DEC); chk_imm("sw_imm", 2'b01);
    cyc(); chk("sw_madr", G_MADR);
    mem_ready = 1'b0;
    cyc(); chk("sw_stl0", G_MWSTL);
    cyc(); chk("sw_stl1", G_MWSTL);
    cyc(); chk("sw_stl2", G_MWSTL);
    mem_ready = 1'b1;
    #1 chk("sw_rdy", G_MWRDY);
    cyc(); chk("sw_done", G_FRDY);

    // R-type add, then funct3 sweep while in EXECR
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
    cyc(); chk("add_dec", G_DEC);
    cyc(); chk("add_exr", G_EXR); chk_alu("add_alu", 3'b000);
    funct3 = 3'b010; #1 chk_alu("slt_alu", 3'b101);
    funct3 = 3'b110; #1 chk_alu("or_alu", 3'b011);
    funct3 = 3'b111; #1 chk_alu("and_alu", 3'b010);
    funct3 = 3'b001; #1 chk_alu("f3_other", 3'b000);
    cyc(); chk("add_awb", G_AWB);
    cyc(); chk("add_done", G_FRDY);

    // sub
    funct3 = 3'b000; funct7b5 = 1'b1;
    cyc(); chk("sub_dec", G_DEC);
    cyc(); chk("sub_exr", G_EXR); chk_alu("sub_alu", 3'b001);
    cyc(); chk("sub_awb", G_AWB);
    cyc(); chk("sub_done", G_FRDY);

    // ori, then addi with funct7b5=1 stays add
    op = 7'b0010011; funct3 = 3'b110; funct7b5 = 1'b1;
    cyc(); chk("ori_dec", G_DEC); chk_imm("ori_imm", 2'b00);
    cyc(); chk("ori_exi", G_EXI); chk_alu("ori_alu", 3'b011);
    funct3 = 3'b000; #1 chk_alu("addi_f7", 3'b000);
    cyc(); chk("ori_awb", G_AWB);
    cyc(); chk("ori_done", G_FRDY);

    // beq taken
    op = 7'b1100011; zero = 1'b1;
    cyc(); chk("beqt_dec", G_DEC); chk_imm("beq_imm", 2'b10);
    cyc(); chk("beqt_st", G_BEQT); chk_alu("beq_sub", 3'b001);
    cyc(); chk("beqt_done", G_FRDY);

    // beq not taken
    zero = 1'b0;
    cyc(); chk("beqn_dec", G_DEC);
    cyc(); chk("beqn_st", G_BEQN);
    cyc(); chk("beqn_done", G_FRDY);

    // jal
    op = 7'b1101111;
    cyc(); chk("jal_dec", G_DEC); chk_imm("jal_imm", 2'b11);
    cyc(); chk("jal_st", G_JAL);
    cyc(); chk("jal_awb", G_AWB);
    cyc(); chk("jal_done", G_FRDY);

    // reset during MEMREAD stall acts without a clock edge
    op = 7'b0000011;
    cyc(); chk("rl_dec", G_DEC);
    cyc(); chk("rl_madr", G_MADR);
    mem_ready = 1'b0;
    cyc(); chk("rl_mrd", G_MRD);
    cyc(); chk("rl_mrd2", G_MRD);
    reset = 1'b1;
    #1 chk("rl_async", G_RST);
    cyc();
    reset = 1'b0; mem_ready = 1'b1;
    #1 chk("rl_fetch", G_FRDY);

    // unlisted opcode
    op = 7'b1111111;
    cyc(); chk("ill_dec", G_DEC); chk_imm("ill_imm", 2'b00);
    cyc();
`ifdef MCCTRL_ILLEGAL_TRAP_EN
    chk("ill_halt", G_HALT);
    checks++;
    assert (illegal === 1'b1) else begin
      errors++;
      $error("FAIL illegal_set: observed %b expected 1", illegal);
    end
    cyc(); cyc(); chk("ill_hold", G_HALT);
    reset = 1'b1;
    #1;
    checks++;
    assert (illegal === 1'b0) else begin
      errors++;
      $error("FAIL illegal_clr: observed %b expected 0", illegal);
    end
    cyc();
    reset = 1'b0;
    #1 chk("ill_recover", G_FRDY);
`else
    chk("ill_nop", G_FRDY);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
